// File: rtl/tob_feed_parser_if.sv
// Byte-serial quote feed in, assembled top-of-book words and status counters out.
// Latency: interface only, no logic.
// Backpressure: s_ready lets the parser stall the feed; tob outputs have no ready.
interface tob_feed_parser_if #(
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             tob_valid;
  logic [63:0]      tob_word0;
  logic [63:0]      tob_word1;
  logic [CNT_W-1:0] msg_count;
  logic [CNT_W-1:0] err_count;

  // Feed source / book consumer side.
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, tob_valid, tob_word0, tob_word1, msg_count, err_count
  );

  // Parser side.
  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, tob_valid, tob_word0, tob_word1, msg_count, err_count
  );
endinterface

// File: rtl/tob_feed_parser.sv
// Assembles 15-byte big-endian quote messages into two top-of-book words; drops and counts bad ones.
// Latency: tob_valid pulses one cycle after the beat carrying byte 14.
// Backpressure: never stalls; s_ready is high from the first edge after reset.
module tob_feed_parser #(
  parameter logic [7:0] MSG_TYPE_QUOTE = 8'h51,
  parameter int         INST_ID_W      = 16,
  parameter int         PRICE_W        = 32,
  parameter int         SIZE_W         = 16,
  parameter int         CNT_W          = 16
) (
  input logic              clk,
  input logic              rst_n,
  tob_feed_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic                 s_ready_q, s_ready_d;
  logic [INST_ID_W-1:0] inst_id_q, inst_id_d;
  logic [PRICE_W-1:0]   bid_px_q, bid_px_d;
  logic [SIZE_W-1:0]    bid_sz_q, bid_sz_d;
  logic [PRICE_W-1:0]   ask_px_q, ask_px_d;
  logic [SIZE_W-1:0]    ask_sz_q, ask_sz_d;
  logic                 tob_valid_q, tob_valid_d;
  logic [63:0]          word0_q, word0_d;
  logic [63:0]          word1_q, word1_d;
  logic [CNT_W-1:0]     msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic beat;
  logic msg_ok;
  logic msg_err;

  assign beat = bus.s_valid & s_ready_q;

  // Next-state: field shifting, message FSM, emit and counter updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s_ready_d   = 1'b1;
    inst_id_d   = inst_id_q;
    bid_px_d    = bid_px_q;
    bid_sz_d    = bid_sz_q;
    ask_px_d    = ask_px_q;
    ask_sz_d    = ask_sz_q;
    tob_valid_d = 1'b0;
    word0_d     = word0_q;
    word1_d     = word1_q;
    msg_cnt_d   = msg_cnt_q;
    err_cnt_d   = err_cnt_q;
    msg_ok      = 1'b0;
    msg_err     = 1'b0;

    // Payload bytes are shifted into the field owning the current index (MSB first).
    if (beat && state_q == RECV) begin
      if (idx_q <= 4'd2)       inst_id_d = {inst_id_q[INST_ID_W-9:0], bus.s_data};
      else if (idx_q <= 4'd6)  bid_px_d  = {bid_px_q[PRICE_W-9:0], bus.s_data};
      else if (idx_q <= 4'd8)  bid_sz_d  = {bid_sz_q[SIZE_W-9:0], bus.s_data};
      else if (idx_q <= 4'd12) ask_px_d  = {ask_px_q[PRICE_W-9:0], bus.s_data};
      else                     ask_sz_d  = {ask_sz_q[SIZE_W-9:0], bus.s_data};
    end

    case (state_q)
      IDLE: begin
        if (beat) begin
          if (bus.s_data == MSG_TYPE_QUOTE) begin
            if (bus.s_last) begin
              msg_err = 1'b1;           // a lone type byte is a short quote
            end else begin
              state_d = RECV;
              idx_d   = 4'd1;
            end
          end else begin
            msg_err = 1'b1;
            if (!bus.s_last) state_d = DROP;
          end
        end
      end
      RECV: begin
        if (beat) begin
          if (bus.s_last) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            // Ask price is complete by byte 12, so the book check uses the stored prices.
            if (idx_q == 4'd14 && bid_px_q < ask_px_q) msg_ok  = 1'b1;
            else                                       msg_err = 1'b1;
          end else if (idx_q == 4'd14) begin
            // Overlong message: count once here, swallow the tail silently in DROP.
            msg_err = 1'b1;
            state_d = DROP;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DROP: begin
        if (beat && bus.s_last) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase

    // ask_sz low byte arrives on the final beat, so the word takes the next-state value.
    if (msg_ok) begin
      tob_valid_d = 1'b1;
      word0_d     = {bid_sz_q, bid_px_q, inst_id_q};
      word1_d     = {16'd0, ask_sz_d, ask_px_q};
      if (msg_cnt_q != '1) msg_cnt_d = msg_cnt_q + 1'b1;
    end
    if (msg_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  // State and output registers; reset discards any partial message without counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      s_ready_q   <= 1'b0;
      inst_id_q   <= '0;
      bid_px_q    <= '0;
      bid_sz_q    <= '0;
      ask_px_q    <= '0;
      ask_sz_q    <= '0;
      tob_valid_q <= 1'b0;
      word0_q     <= '0;
      word1_q     <= '0;
      msg_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      inst_id_q   <= inst_id_d;
      bid_px_q    <= bid_px_d;
      bid_sz_q    <= bid_sz_d;
      ask_px_q    <= ask_px_d;
      ask_sz_q    <= ask_sz_d;
      tob_valid_q <= tob_valid_d;
      word0_q     <= word0_d;
      word1_q     <= word1_d;
      msg_cnt_q   <= msg_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.tob_valid = tob_valid_q;
  assign bus.tob_word0 = word0_q;
  assign bus.tob_word1 = word1_q;
  assign bus.msg_count = msg_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule
